bpsk_rx_ctrl: RTL and testbench

//  Receive-side counterpart of the BPSK transmit controller. Takes the hard-sliced carrier phase from the demodulator.

---
 rtl/bpsk_pkg.sv | 27 ++
 rtl/bpsk_rx_ctrl_if.sv | 29 ++
 rtl/bpsk_rx_bit_sync.sv | 83 ++++++++
 rtl/bpsk_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bpsk_rx_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpsk_pkg                                                        |
// | Purpose  : Shared definitions for the BPSK receive controller: FSM state   |
// |            encoding, bit-timing counter width and the clocks-per-bit       |
// |            helper used to size the timing counter.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package bpsk_pkg;

  // Width of the bit-timing counter; covers long bit periods at high clk rates.
  localparam int c_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RECV = 2'd2
  } rx_state_t;

  // Integer clocks per bit period.
  function automatic int clks_per_bit(input int ref_hz, input int baud);
    return ref_hz / baud;
  endfunction

endpackage : bpsk_pkg
`default_nettype wire

// File: rtl/bpsk_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpsk_rx_ctrl_if                                                 |
// | Purpose  : BRAM write-port bundle between the receive controller and the   |
// |            PS-visible receive buffer RAM.                                  |
// | Ports    : ram_clk, ram_en, ram_we[0:0], ram_addr, ram_wr_data, ram_rst    |
// |            master = controller side (drives), slave = RAM side (receives)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface bpsk_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  ram_clk;
  logic                  ram_en;
  logic [0:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rst;

  modport master (
    output ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, ram_rst
  );

  modport slave (
    input ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, ram_rst
  );
endinterface : bpsk_rx_ctrl_if
`default_nettype wire

// File: rtl/bpsk_rx_bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpsk_rx_bit_sync                                                |
// | Purpose  : Front end of the receiver. Synchronises the sliced phase,       |
// |            rejects short glitches and runs the bit-timing counter that     |
// |            produces a mid-bit sample strobe.                               |
// | Ports    : clk, rst_n      clock / async active-low reset                  |
// |            clr             hold timing counter at 0, suppress strobe       |
// |            phase_in        raw sliced phase (asynchronous)                 |
// |            ph_f            filtered phase level                            |
// |            sample_stb      1-cycle mid-bit sample strobe                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bpsk_rx_bit_sync
  import bpsk_pkg::*;
#(
  parameter int CLKS_PER_BIT = 13333,
  parameter int GLITCH_CYC   = 3
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  clr,
  input  wire  phase_in,
  output logic ph_f,
  output logic sample_stb
);

  localparam logic [c_CNT_W-1:0] c_CNT_MAX     = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MID     = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]         c_GLITCH_LAST = 8'(GLITCH_CYC - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_ph_f;
  logic [7:0]         r_glitch_cnt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_diff;
  logic               w_edge;

  assign w_diff = r_sync2 ^ r_ph_f;
  // The edge is taken on the GLITCH_CYC-th consecutive cycle of disagreement.
  assign w_edge = w_diff && (r_glitch_cnt == c_GLITCH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= phase_in;
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: any return to the filtered level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
      r_ph_f       <= 1'b0;
    end else begin
      if (!w_diff || w_edge) r_glitch_cnt <= '0;
      else                   r_glitch_cnt <= r_glitch_cnt + 1'b1;
      if (w_edge) r_ph_f <= r_sync2;
    end
  end

  // Timing counter re-aligns on each accepted edge and free-runs through
  // edge-less runs at the nominal bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_edge || (r_cnt == c_CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An edge in the strobe cycle wins: the counter clears and no sample is taken.
  assign sample_stb = !clr && !w_edge && (r_cnt == c_CNT_MID);
  assign ph_f       = r_ph_f;

endmodule : bpsk_rx_bit_sync
`default_nettype wire

// File: rtl/bpsk_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpsk_rx_ctrl                                                    |
// | Purpose  : BPSK receive controller. Differentially decodes the filtered    |
// |            phase, assembles bytes MSB first, optionally hunts for a sync   |
// |            byte and writes each frame into a BRAM port.                    |
// | Ports    : clk, rst_n      clock / async active-low reset                  |
// |            rx_en           receive enable (level)                          |
// |            phase_in        sliced phase from the demodulator               |
// |            ram             BRAM write port (bpsk_rx_ctrl_if.master)        |
// |            bit_out         last decoded bit                                |
// |            bit_valid       1-cycle strobe, bit_out updated                 |
// |            sync_lock       high while receiving a frame                    |
// |            frame_done      pulse on the write to the last frame address    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bpsk_rx_ctrl
  import bpsk_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    FRAME_LENGTH = 150,
  parameter int                    REF_CLK_FREQ = 128000000,
  parameter int                    BAUDRATE     = 9600,
  parameter int                    GLITCH_CYC   = 3,
  parameter int                    SYNC_EN      = 1,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 'h7E
) (
  input  wire           clk,
  input  wire           rst_n,
  input  wire           rx_en,
  input  wire           phase_in,
  bpsk_rx_ctrl_if.master ram,
  output logic          bit_out,
  output logic          bit_valid,
  output logic          sync_lock,
  output logic          frame_done
);

  localparam int                      c_CPB       = clks_per_bit(REF_CLK_FREQ, BAUDRATE);
  localparam int                      c_BCNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_BCNT_W-1:0]     c_BCNT_LAST = c_BCNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0]   c_ADDR_LAST = ADDR_WIDTH'(FRAME_LENGTH - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic                  w_clr;
  logic                  w_ph_f;
  logic                  w_stb;
  logic                  w_bit;
  logic                  w_byte_done;
  logic                  w_sync_hit;
  logic                  r_prev_phase;
  logic                  r_first;
  logic                  r_bit_out;
  logic                  r_bit_valid;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_BCNT_W-1:0]   r_bit_cnt;
  logic                  r_ram_en;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_addr;

  assign w_clr = (r_state == ST_IDLE);

  bpsk_rx_bit_sync #(
    .CLKS_PER_BIT (c_CPB),
    .GLITCH_CYC   (GLITCH_CYC)
  ) u_bit_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_clr),
    .phase_in   (phase_in),
    .ph_f       (w_ph_f),
    .sample_stb (w_stb)
  );

  // Differential decode: a phase change between samples is a '1'.
  assign w_bit = w_ph_f ^ r_prev_phase;

  // The first strobe after IDLE only establishes the reference phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_phase <= 1'b0;
      r_first      <= 1'b1;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_shift      <= '0;
    end else if (w_clr) begin
      r_first      <= 1'b1;
      r_bit_valid  <= 1'b0;
      r_shift      <= '0;
    end else begin
      r_bit_valid <= 1'b0;
      if (w_stb) begin
        r_prev_phase <= w_ph_f;
        r_first      <= 1'b0;
        if (!r_first) begin
          r_bit_out   <= w_bit;
          r_bit_valid <= 1'b1;
          r_shift     <= {r_shift[DATA_WIDTH-2:0], w_bit};
        end
      end
    end
  end

  // r_shift is checked in the cycle it has just absorbed a new bit.
  assign w_sync_hit  = r_bit_valid && (r_shift == SYNC_BYTE);
  // A byte that completes as rx_en drops is discarded with the partial frame.
  assign w_byte_done = (r_state == ST_RECV) && rx_en && r_bit_valid &&
                       (r_bit_cnt == c_BCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if ((r_state != ST_RECV) || !rx_en) begin
      r_bit_cnt <= '0;
    end else if (r_bit_valid) begin
      r_bit_cnt <= (r_bit_cnt == c_BCNT_LAST) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // Write is issued the cycle after the byte completes; the address advances
  // the cycle after the write. A write already in flight when rx_en drops
  // still uses the current address before it returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en     <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_data    <= '0;
      r_addr       <= '0;
    end else begin
      r_ram_en     <= w_byte_done;
      r_frame_done <= w_byte_done && (r_addr == c_ADDR_LAST);
      if (w_byte_done) r_wr_data <= r_shift;
      if ((r_state == ST_IDLE) || !rx_en) begin
        r_addr <= '0;
      end else if (r_ram_en) begin
        r_addr <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_en) w_state_nxt = (SYNC_EN != 0) ? ST_HUNT : ST_RECV;
      end
      ST_HUNT: begin
        if (!rx_en)          w_state_nxt = ST_IDLE;
        else if (w_sync_hit) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (!rx_en)                             w_state_nxt = ST_IDLE;
        else if (r_frame_done && (SYNC_EN != 0)) w_state_nxt = ST_HUNT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sync_lock = 1'b0;
    if (r_state == ST_RECV) sync_lock = 1'b1;
  end

  assign bit_out         = r_bit_out;
  assign bit_valid       = r_bit_valid;
  assign frame_done      = r_frame_done;
  assign ram.ram_clk     = clk;
  assign ram.ram_en      = r_ram_en;
  assign ram.ram_we      = r_ram_en;
  assign ram.ram_addr    = r_addr;
  assign ram.ram_wr_data = r_wr_data;
  assign ram.ram_rst     = 1'b0;

endmodule : bpsk_rx_ctrl
`default_nettype wire

// File: tb/tb_bpsk_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bpsk_rx_ctrl                                                 |
// | Purpose  : Directed self-checking bench for bpsk_rx_ctrl. Two instances    |
// |            share clock, reset and phase line: one free-running (no sync    |
// |            hunt), one hunting for 0x7E. Bit period 100 clk, 6-byte frames. |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bpsk_rx_ctrl;

  localparam int c_PER = 100;
  localparam int c_FL  = 6;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic rx_en0   = 1'b0;
  logic rx_en1   = 1'b0;
  logic phase_in = 1'b0;

  always #5 clk = ~clk;

  bpsk_rx_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) ram0 ();
  bpsk_rx_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) ram1 ();

  logic bo0, bv0, sl0, fd0;
  logic bo1, bv1, sl1, fd1;

  bpsk_rx_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAME_LENGTH(c_FL),
    .REF_CLK_FREQ(960000), .BAUDRATE(9600), .GLITCH_CYC(3),
    .SYNC_EN(0), .SYNC_BYTE(8'h7E)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en0), .phase_in(phase_in), .ram(ram0),
    .bit_out(bo0), .bit_valid(bv0), .sync_lock(sl0), .frame_done(fd0)
  );

  bpsk_rx_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAME_LENGTH(c_FL),
    .REF_CLK_FREQ(960000), .BAUDRATE(9600), .GLITCH_CYC(3),
    .SYNC_EN(1), .SYNC_BYTE(8'h7E)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en1), .phase_in(phase_in), .ram(ram1),
    .bit_out(bo1), .bit_valid(bv1), .sync_lock(sl1), .frame_done(fd1)
  );

  // RAM models and write/frame counters, sampled on the falling edge.
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  int wr0 = 0, wr1 = 0, fdc0 = 0, fdc1 = 0;
  int fda0 = -1, fda1 = -1;

  always @(negedge clk) begin
    if (ram0.ram_en) begin
      mem0[ram0.ram_addr] <= ram0.ram_wr_data;
      wr0 <= wr0 + 1;
    end
    if (ram1.ram_en) begin
      mem1[ram1.ram_addr] <= ram1.ram_wr_data;
      wr1 <= wr1 + 1;
    end
    if (fd0) begin
      fdc0 <= fdc0 + 1;
      fda0 <= int'(ram0.ram_addr);
    end
    if (fd1) begin
      fdc1 <= fdc1 + 1;
      fda1 <= int'(ram1.ram_addr);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One differentially-encoded symbol: a '1' flips the carrier phase.
  task automatic send_sym(input logic b, input int per);
    if (b) phase_in = ~phase_in;
    tick(per);
  endtask

  task automatic send_byte(input logic [7:0] v, input int per);
    for (int i = 7; i >= 0; i--) send_sym(v[i], per);
  endtask

  // A '0' symbol carrying a 2-cycle phase pulse near mid-bit.
  task automatic send_glitch_zero(input int per);
    tick(45);
    phase_in = ~phase_in;
    tick(2);
    phase_in = ~phase_in;
    tick(per - 47);
  endtask

  int base_wr, base_fd;
  logic [36:0] pre_bits;
  logic [7:0]  alt_data [0:5];
  logic [7:0]  sync_data [0:5];
  int          pers [0:1];

  initial begin
    pre_bits  = 37'h0A5C31B29;
    alt_data  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    sync_data = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    pers      = '{99, 101};

    // Power-on reset state
    tick(3);
    chk("por_sync_lock", 32'(sl1), 32'd0);
    chk("por_ram_en", 32'(ram0.ram_en), 32'd0);
    chk("por_ram_addr", 32'(ram0.ram_addr), 32'd0);
    chk("por_ram_rst", 32'(ram1.ram_rst), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Free-running frame 0x00..0x05 with a 2-cycle glitch inside byte 0
    base_wr = wr0;
    base_fd = fdc0;
    rx_en0  = 1'b1;
    send_sym(1'b0, c_PER);                       // reference symbol
    for (int i = 0; i < 3; i++) send_sym(1'b0, c_PER);
    send_glitch_zero(c_PER);
    for (int i = 0; i < 4; i++) send_sym(1'b0, c_PER);
    for (int b = 1; b < c_FL; b++) send_byte(8'(b), c_PER);
    tick(5);
    for (int a = 0; a < c_FL; a++) chk($sformatf("seq_ram[%0d]", a), 32'(mem0[a]), 32'(a));
    chk("seq_writes", 32'(wr0 - base_wr), 32'(c_FL));
    chk("seq_frame_done_cnt", 32'(fdc0 - base_fd), 32'd1);
    chk("seq_frame_done_addr", 32'(fda0), 32'(c_FL - 1));
    chk("seq_addr_wrapped", 32'(ram0.ram_addr), 32'd0);
    chk("seq_lock_recv", 32'(sl0), 32'd1);
    rx_en0 = 1'b0;
    tick(2);
    chk("seq_lock_idle", 32'(sl0), 32'd0);

    // Bit period off by -1% / +1%, alternating 0x00/0xFF
    for (int p = 0; p < 2; p++) begin
      base_wr = wr0;
      rx_en0  = 1'b1;
      send_sym(1'b0, pers[p]);
      for (int b = 0; b < c_FL; b++) send_byte(alt_data[b], pers[p]);
      tick(5);
      for (int a = 0; a < c_FL; a++)
        chk($sformatf("tol%0d_ram[%0d]", pers[p], a), 32'(mem0[a]), 32'(alt_data[a]));
      chk($sformatf("tol%0d_writes", pers[p]), 32'(wr0 - base_wr), 32'(c_FL));
      rx_en0 = 1'b0;
      tick(3);
    end

    // Sync hunt: 37 pre-bits, 0x7E, then a frame
    base_wr = wr1;
    base_fd = fdc1;
    rx_en1  = 1'b1;
    send_sym(1'b0, c_PER);
    for (int i = 36; i >= 0; i--) send_sym(pre_bits[i], c_PER);
    chk("hunt_no_lock", 32'(sl1), 32'd0);
    send_byte(8'h7E, c_PER);
    chk("hunt_locked", 32'(sl1), 32'd1);
    for (int b = 0; b < c_FL; b++) send_byte(sync_data[b], c_PER);
    tick(5);
    for (int a = 0; a < c_FL; a++) chk($sformatf("sync_ram[%0d]", a), 32'(mem1[a]), 32'(sync_data[a]));
    chk("sync_writes", 32'(wr1 - base_wr), 32'(c_FL));
    chk("sync_frame_done_cnt", 32'(fdc1 - base_fd), 32'd1);
    chk("sync_frame_done_addr", 32'(fda1), 32'(c_FL - 1));
    chk("sync_back_to_hunt", 32'(sl1), 32'd0);
    chk("sync_addr_wrapped", 32'(ram1.ram_addr), 32'd0);

    // rx_en dropped four bits into byte 2
    base_wr = wr1;
    send_byte(8'h7E, c_PER);
    send_byte(8'h11, c_PER);
    send_byte(8'h22, c_PER);
    for (int i = 7; i >= 4; i--) send_sym(1'(8'h33 >> i), c_PER);
    chk("drop_addr_before", 32'(ram1.ram_addr), 32'd2);
    rx_en1 = 1'b0;
    tick(1);
    chk("drop_lock_idle", 32'(sl1), 32'd0);
    chk("drop_addr_zero", 32'(ram1.ram_addr), 32'd0);
    tick(c_PER * 4);
    chk("drop_writes", 32'(wr1 - base_wr), 32'd2);
    chk("drop_ram[0]", 32'(mem1[0]), 32'h11);
    chk("drop_ram[1]", 32'(mem1[1]), 32'h22);

    // Re-enable: hunt and lock on the next sync byte
    base_wr = wr1;
    rx_en1  = 1'b1;
    send_sym(1'b0, c_PER);
    send_byte(8'h7E, c_PER);
    send_byte(8'h44, c_PER);
    tick(5);
    chk("reen_locked", 32'(sl1), 32'd1);
    chk("reen_writes", 32'(wr1 - base_wr), 32'd1);
    chk("reen_ram[0]", 32'(mem1[0]), 32'h44);
    chk("reen_addr", 32'(ram1.ram_addr), 32'd1);

    // Asynchronous reset in the middle of a byte
    base_wr = wr1;
    send_sym(1'b1, c_PER);
    send_sym(1'b0, c_PER);
    send_sym(1'b1, c_PER);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sync_lock", 32'(sl1), 32'd0);
    chk("rst_ram_addr", 32'(ram1.ram_addr), 32'd0);
    chk("rst_ram_en", 32'(ram1.ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram1.ram_we), 32'd0);
    chk("rst_wr_data", 32'(ram1.ram_wr_data), 32'd0);
    chk("rst_bit_out", 32'(bo1), 32'd0);
    chk("rst_bit_valid", 32'(bv1), 32'd0);
    chk("rst_frame_done", 32'(fd1), 32'd0);
    tick(c_PER * 6);
    chk("rst_no_write", 32'(wr1 - base_wr), 32'd0);
    rx_en1 = 1'b0;
    rst_n  = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bpsk_rx_ctrl
`default_nettype wire
